// File: rtl/a_pipe_pkg.sv
// Shared datapath widths, register/data types and immediate sign-extension for the A3 pipeline.
package a_pipe_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int IMM_W  = 3;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    function automatic data_t sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/a3_fwd_unit.sv
// Operand bypass: selects the EX/WB result over the ID-read value when it targets the same register.
// Purely combinational, no backpressure.
module a3_fwd_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    output logic [DATA_W-1:0] op1_o,
    output logic [DATA_W-1:0] op2_o,
    output logic              fwd1_o,
    output logic              fwd2_o
);

    always_comb begin
        fwd1_o = wb_we_i && (wb_rd_i == rs1_i);
        fwd2_o = wb_we_i && (wb_rd_i == rd_i);
        op1_o  = fwd1_o ? wb_data_i : data1_i;
        op2_o  = fwd2_o ? wb_data_i : data2_i;
    end

endmodule

// File: rtl/a3_ex_wb.sv
// Execute stage (ADD / sign-extend) plus EX/WB register; result on wb_* one clock after operands, no backpressure.
// EX_STATUS_FLAGS_EN adds zero_out/carry_out, updated only on instructions that write back.
module a3_ex_wb #(
    parameter int DATA_W = a_pipe_pkg::DATA_W,
    parameter int ADDR_W = a_pipe_pkg::ADDR_W,
    parameter int IMM_W  = a_pipe_pkg::IMM_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SEtoReg_in,
    input  logic              WriteReg_in,
    input  logic [ADDR_W-1:0] rs1_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0] data1_in,
    input  logic [DATA_W-1:0] data2_in,
    input  logic [IMM_W-1:0]  unextended_in,
    input  logic              flush_in,
    output logic              wb_we_out,
    output logic [ADDR_W-1:0] wb_rd_out,
    output logic [DATA_W-1:0] wb_data_out,
    output logic              fwd1_out,
    output logic              fwd2_out,
    output logic [CNT_W-1:0]  retired_cnt_out
`ifdef EX_STATUS_FLAGS_EN
    ,
    output logic              zero_out,
    output logic              carry_out
`endif
);

    import a_pipe_pkg::sext_imm;

    logic [DATA_W-1:0] op1, op2, result;
    logic [DATA_W:0]   sum;

    logic              we_d, we_q;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    a3_fwd_unit #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd (
        .wb_we_i   (we_q),
        .wb_rd_i   (rd_q),
        .wb_data_i (data_q),
        .rs1_i     (rs1_in),
        .rd_i      (rd_in),
        .data1_i   (data1_in),
        .data2_i   (data2_in),
        .op1_o     (op1),
        .op2_o     (op2),
        .fwd1_o    (fwd1_out),
        .fwd2_o    (fwd2_out)
    );

    always_comb begin
        sum    = {1'b0, op1} + {1'b0, op2};
        result = SEtoReg_in ? sext_imm(unextended_in) : sum[DATA_W-1:0];
        we_d   = WriteReg_in & ~flush_in;
        cnt_d  = we_d ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // rd/data load every cycle; they are only meaningful while we_q is set
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            we_q   <= we_d;
            rd_q   <= rd_in;
            data_q <= result;
            cnt_q  <= cnt_d;
        end
    end

`ifdef EX_STATUS_FLAGS_EN
    logic zero_d, zero_q, carry_d, carry_q;

    always_comb begin
        zero_d  = zero_q;
        carry_d = carry_q;
        if (we_d) begin
            zero_d  = (result == '0);
            carry_d = ~SEtoReg_in & sum[DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign zero_out  = zero_q;
    assign carry_out = carry_q;
`endif

    assign wb_we_out       = we_q;
    assign wb_rd_out       = rd_q;
    assign wb_data_out     = data_q;
    assign retired_cnt_out = cnt_q;

endmodule

// File: tb/tb_a3_ex_wb.sv
// Directed bench for a3_ex_wb built with a 4-bit retired counter so the wrap is reachable quickly.
module tb_a3_ex_wb;

    logic       clk;
    logic       reset;
    logic       SEtoReg_in;
    logic       WriteReg_in;
    logic [2:0] rs1_in;
    logic [2:0] rd_in;
    logic [7:0] data1_in;
    logic [7:0] data2_in;
    logic [2:0] unextended_in;
    logic       flush_in;
    logic       wb_we_out;
    logic [2:0] wb_rd_out;
    logic [7:0] wb_data_out;
    logic       fwd1_out;
    logic       fwd2_out;
    logic [3:0] retired_cnt_out;
`ifdef EX_STATUS_FLAGS_EN
    logic       zero_out;
    logic       carry_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_cnt;

    a3_ex_wb #(
        .DATA_W (8),
        .ADDR_W (3),
        .IMM_W  (3),
        .CNT_W  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .SEtoReg_in      (SEtoReg_in),
        .WriteReg_in     (WriteReg_in),
        .rs1_in          (rs1_in),
        .rd_in           (rd_in),
        .data1_in        (data1_in),
        .data2_in        (data2_in),
        .unextended_in   (unextended_in),
        .flush_in        (flush_in),
        .wb_we_out       (wb_we_out),
        .wb_rd_out       (wb_rd_out),
        .wb_data_out     (wb_data_out),
        .fwd1_out        (fwd1_out),
        .fwd2_out        (fwd2_out),
        .retired_cnt_out (retired_cnt_out)
`ifdef EX_STATUS_FLAGS_EN
        ,
        .zero_out        (zero_out),
        .carry_out       (carry_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic se, input logic wr, input logic [2:0] rs1,
                         input logic [2:0] rd, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [2:0] imm, input logic fl);
        SEtoReg_in    = se;
        WriteReg_in   = wr;
        rs1_in        = rs1;
        rd_in         = rd;
        data1_in      = d1;
        data2_in      = d2;
        unextended_in = imm;
        flush_in      = fl;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 1'b1, 3'd0, 3'd5, 8'h00, 8'h00, 3'b011, 1'b0);
        step();
        step();
        exp_cnt = 4'd0;
        n_checks++; if (wb_we_out !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", wb_we_out); end
        n_checks++; if (wb_rd_out !== 3'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", wb_rd_out); end
        n_checks++; if (wb_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", wb_data_out); end
        n_checks++; if (retired_cnt_out !== exp_cnt) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", retired_cnt_out); end
`ifdef EX_STATUS_FLAGS_EN
        n_checks++; if ({zero_out, carry_out} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {zero_out, carry_out}); end
`endif
        reset = 1'b1;
    endtask

    task automatic test_se();
        drive(1'b1, 1'b1, 3'd0, 3'd1, 8'h00, 8'h00, 3'b110, 1'b0);
        step();
        exp_cnt = exp_cnt + 4'd1;
        n_checks++; if (wb_we_out !== 1'b1) begin n_fail++; $display("FAIL se_we got %b want 1", wb_we_out); end
        n_checks++; if (wb_rd_out !== 3'd1) begin n_fail++; $display("FAIL se_rd got %0d want 1", wb_rd_out); end
        n_checks++; if (wb_data_out !== 8'hFE) begin n_fail++; $display("FAIL se_neg_data got %h want fe", wb_data_out); end
        n_checks++; if (retired_cnt_out !== exp_cnt) begin n_fail++; $display("FAIL se_cnt got %0d want %0d", retired_cnt_out, exp_cnt); end
        drive(1'b1, 1'b1, 3'd0, 3'd1, 8'h00, 8'h00, 3'b001, 1'b0);
        // SE ignores the operand but the rd match is still reported
        n_checks++; if (fwd2_out !== 1'b1) begin n_fail++; $display("FAIL se_fwd2 got %b want 1", fwd2_out); end
        step();
        exp_cnt = exp_cnt + 4'd1;
        n_checks++; if (wb_data_out !== 8'h01) begin n_fail++; $display("FAIL se_pos_data got %h want 01", wb_data_out); end
        n_checks++; if (retired_cnt_out !== exp_cnt) begin n_fail++; $display("FAIL se_cnt2 got %0d want %0d", retired_cnt_out, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 3'd0, 3'd2, 8'h10, 8'h20, 3'b000, 1'b0);
        n_checks++; if ({fwd1_out, fwd2_out} !== 2'b00) begin n_fail++; $display("FAIL add_nofwd got %b want 00", {fwd1_out, fwd2_out}); end
        step();
        exp_cnt = exp_cnt + 4'd1;
        n_checks++; if (wb_data_out !== 8'h30) begin n_fail++; $display("FAIL add_data got %h want 30", wb_data_out); end
        n_checks++; if (wb_rd_out !== 3'd2) begin n_fail++; $display("FAIL add_rd got %0d want 2", wb_rd_out); end
        drive(1'b0, 1'b1, 3'd2, 3'd3, 8'h00, 8'h05, 3'b000, 1'b0);
        n_checks++; if ({fwd1_out, fwd2_out} !== 2'b10) begin n_fail++; $display("FAIL add_fwd1 got %b want 10", {fwd1_out, fwd2_out}); end
        step();
        exp_cnt = exp_cnt + 4'd1;
        n_checks++; if (wb_data_out !== 8'h35) begin n_fail++; $display("FAIL add_fwd_data got %h want 35", wb_data_out); end
        n_checks++; if (wb_rd_out !== 3'd3) begin n_fail++; $display("FAIL add_fwd_rd got %0d want 3", wb_rd_out); end
    endtask

    task automatic test_double_fwd();
        drive(1'b0, 1'b1, 3'd0, 3'd4, 8'h80, 8'h00, 3'b000, 1'b0);
        step();
        exp_cnt = exp_cnt + 4'd1;
        n_checks++; if (wb_data_out !== 8'h80) begin n_fail++; $display("FAIL dbl_setup got %h want 80", wb_data_out); end
        drive(1'b0, 1'b1, 3'd4, 3'd4, 8'h11, 8'h22, 3'b000, 1'b0);
        n_checks++; if ({fwd1_out, fwd2_out} !== 2'b11) begin n_fail++; $display("FAIL dbl_fwd got %b want 11", {fwd1_out, fwd2_out}); end
        step();
        exp_cnt = exp_cnt + 4'd1;
        n_checks++; if (wb_data_out !== 8'h00) begin n_fail++; $display("FAIL dbl_wrap_data got %h want 00", wb_data_out); end
        n_checks++; if (retired_cnt_out !== exp_cnt) begin n_fail++; $display("FAIL dbl_cnt got %0d want %0d", retired_cnt_out, exp_cnt); end
`ifdef EX_STATUS_FLAGS_EN
        n_checks++; if ({zero_out, carry_out} !== 2'b11) begin n_fail++; $display("FAIL dbl_flags got %b want 11", {zero_out, carry_out}); end
`endif
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 3'd0, 3'd5, 8'h00, 8'h00, 3'b011, 1'b1);
        step();
        n_checks++; if (wb_we_out !== 1'b0) begin n_fail++; $display("FAIL flush_we got %b want 0", wb_we_out); end
        n_checks++; if (retired_cnt_out !== exp_cnt) begin n_fail++; $display("FAIL flush_cnt got %0d want %0d", retired_cnt_out, exp_cnt); end
`ifdef EX_STATUS_FLAGS_EN
        n_checks++; if ({zero_out, carry_out} !== 2'b11) begin n_fail++; $display("FAIL flush_flags_held got %b want 11", {zero_out, carry_out}); end
`endif
        drive(1'b0, 1'b1, 3'd5, 3'd6, 8'h07, 8'h01, 3'b000, 1'b0);
        n_checks++; if (fwd1_out !== 1'b0) begin n_fail++; $display("FAIL flush_nofwd got %b want 0", fwd1_out); end
        step();
        exp_cnt = exp_cnt + 4'd1;
        n_checks++; if (wb_data_out !== 8'h08) begin n_fail++; $display("FAIL flush_next_data got %h want 08", wb_data_out); end
`ifdef EX_STATUS_FLAGS_EN
        n_checks++; if ({zero_out, carry_out} !== 2'b00) begin n_fail++; $display("FAIL flush_next_flags got %b want 00", {zero_out, carry_out}); end
`endif
        reset = 1'b0;
        drive(1'b0, 1'b1, 3'd0, 3'd7, 8'h01, 8'h02, 3'b000, 1'b1);
        step();
        exp_cnt = 4'd0;
        n_checks++; if ({wb_we_out, wb_rd_out, wb_data_out} !== 12'h000) begin n_fail++; $display("FAIL flush_reset_wb got %h want 000", {wb_we_out, wb_rd_out, wb_data_out}); end
        n_checks++; if (retired_cnt_out !== exp_cnt) begin n_fail++; $display("FAIL flush_reset_cnt got %0d want 0", retired_cnt_out); end
        reset = 1'b1;
    endtask

    task automatic test_counter();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 3'd0, 3'd0, 8'h00, 8'h00, 3'b001, 1'b0);
            step();
            exp_cnt = exp_cnt + 4'd1;
        end
        n_checks++; if (retired_cnt_out !== 4'd15) begin n_fail++; $display("FAIL cnt_max got %0d want 15", retired_cnt_out); end
        drive(1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 3'b001, 1'b0);
        step();
        n_checks++; if ({wb_we_out, retired_cnt_out} !== 5'b0_1111) begin n_fail++; $display("FAIL cnt_nowrite got %b want 01111", {wb_we_out, retired_cnt_out}); end
        drive(1'b1, 1'b1, 3'd0, 3'd0, 8'h00, 8'h00, 3'b001, 1'b0);
        step();
        exp_cnt = exp_cnt + 4'd1;
        n_checks++; if (retired_cnt_out !== 4'd0) begin n_fail++; $display("FAIL cnt_wrap got %0d want 0", retired_cnt_out); end
    endtask

    initial begin
        reset = 1'b0;
        exp_cnt = 4'd0;
        drive(1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 3'b000, 1'b0);
        test_reset();
        test_se();
        test_back_to_back();
        test_double_fwd();
        test_flush();
        test_counter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
